io_uart_port: RTL and testbench
===============================

# io_uart_port

Memory-mapped UART peripheral on the processor I/O port bus, downstream of `processor_top`. It decodes `IO_port_ID` together with the write and read strobes, and buffers outgoing bytes in a TX FIFO that feeds an 8N1 serializer. It deserializes the `uart_rx` line into an RX FIFO and returns RX data and TX/RX status bytes on `IO_read_data`.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Minimum 4.
- `TX_DEPTH`, default 8: TX FIFO entries. Power of 2, ≥2.
- `RX_DEPTH`, default 8: RX FIFO entries. Power of 2, ≥2.
- `clk100` input, 1 bit: sole clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `IO_port_ID` input, 8 bits: port address from the processor.
- `IO_write_data` input, 8 bits: write payload.
- `IO_write_strobe` input, 1 bit: one-cycle write pulse.
- `IO_read_strobe` input, 1 bit: one-cycle read pulse.
- `IO_read_data` output, 8 bits: read data (combinational decode).
- `uart_tx` output, 1 bit: serial out, idle high.
- `uart_rx` input, 1 bit: serial in, asynchronous to `clk100`.

## Operation
- Port map:
  - 0x01 write pushes a byte to the TX FIFO. 0x01 read returns the RX FIFO head and pops it.
  - 0x02 read returns 0xFF if the RX FIFO is non-empty, else 0x00.
  - 0x03 read returns 0xFF if the TX FIFO is full, else 0x00.
  - Reads of any other port return 0xFF. Writes to any other port are ignored.
- `IO_read_data` is decoded from `IO_port_ID` every cycle, regardless of the strobe. The RX pop happens on the edge where `IO_read_strobe`=1 and port=0x01.
- Push to a full TX FIFO: the byte is dropped, and state and pointers are unchanged. Full is evaluated before the edge, so a push is refused even if the serializer pops the same cycle.
- Port 0x01 read while the RX FIFO is empty returns 0x00, with no pointer change.
- A received byte that arrives with the RX FIFO full is dropped.
- TX FSM: IDLE→START→DATA→STOP→IDLE, or STOP→START directly if the FIFO is non-empty.
  - The byte is popped when the FSM leaves IDLE, or when it goes STOP→START.
  - Frame: start 0, 8 data bits LSB first, stop 1; each bit lasts exactly `CLKS_PER_BIT` cycles.
- RX FSM: IDLE→START→DATA→STOP→IDLE.
  - `uart_rx` passes through a 2-flop synchronizer.
  - IDLE waits for the synchronized line to be low.
  - START waits `CLKS_PER_BIT/2` cycles (integer division). If the line is high, the start is false: return to IDLE.
  - Each data bit is sampled every `CLKS_PER_BIT` cycles after that.
  - At the stop-bit sample: if 1, push the byte; if 0 (framing error), discard the byte. Either way return to IDLE.
- Reset values:
  - `uart_tx`=1; both FSMs in IDLE; FIFOs empty; bit counters and shift registers 0.
  - `IO_read_data` after reset is 0x00 for ports 0x01, 0x02 and 0x03, and 0xFF for any other port.
- Reset mid-frame aborts immediately: `uart_tx` returns high asynchronously and partial RX bytes are lost.

## Timing
- Write strobe at edge N: the TX FIFO is non-empty after N, and `uart_tx` falls after edge N+1.
- Full-frame duration: 10·`CLKS_PER_BIT` cycles. Back-to-back frames have no idle gap.
- RX push occurs 2 synchronizer cycles + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` after the start-bit falling edge on `uart_rx`, ±1 cycle.
- Port 0x02 reads 0xFF on the cycle after the push edge.
- Status ports reflect FIFO state registered at the preceding edge.

## Configuration
- `IO_UART_RX_EN`:
  - When defined: the receiver, synchronizer and RX FIFO are built.
  - When undefined: no RX logic; `uart_rx` is unused; ports 0x01-read and 0x02 return 0x00; read strobes have no effect. The TX path is identical in both builds.

## Structure
- Package `io_uart_pkg`:
  - port ID constants: `PORT_DATA`=0x01, `PORT_RX_AVAIL`=0x02, `PORT_TX_FULL`=0x03;
  - status bytes 0xFF/0x00;
  - default read 0xFF;
  - TX and RX state enums.
- Sub-module `io_uart_fifo`: synchronous FIFO, parameter `DEPTH`, 8-bit data, ports `push`/`pop`/`din`/`dout`/`full`/`empty`. `dout` shows the head combinationally. Instantiated once for TX and once for RX.

## Test plan
- Bench runs with `CLKS_PER_BIT`=16.
- After reset: `uart_tx`=1; port 0x02→0x00, 0x03→0x00, 0x07→0xFF.
- Write 0xA5 to 0x01 → `uart_tx` emits 0,1,0,1,0,0,1,0,1,1, each held 16 cycles; start bit falls 2 edges after the strobe.
- 9 writes (0x00..0x08) with `TX_DEPTH`=8 at one write per cycle → port 0x03 reads 0xFF after the 8th push, while the first byte is still queued; 0x08 is dropped; 8 frames are emitted contiguously.
- Drive a 0x3C frame on `uart_rx` → port 0x02 reads 0xFF; port 0x01 read returns 0x3C; port 0x02 then reads 0x00.
- RX glitch low for 4 cycles → no push. Frame with stop bit 0 → no push; port 0x02 stays 0x00.
- Assert `reset` mid-TX-frame → `uart_tx`=1 immediately; FIFOs empty; the next write transmits a clean frame.

Source files
------------

// File: rtl/io_uart_pkg.sv
// io_uart_pkg: port map, status bytes and FSM state types
// shared by the io_uart_port peripheral.
package io_uart_pkg;

  localparam logic [7:0] PORT_DATA     = 8'h01;
  localparam logic [7:0] PORT_RX_AVAIL = 8'h02;
  localparam logic [7:0] PORT_TX_FULL  = 8'h03;

  localparam logic [7:0] STAT_SET     = 8'hFF;
  localparam logic [7:0] STAT_CLR     = 8'h00;
  localparam logic [7:0] READ_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/io_uart_fifo.sv
// io_uart_fifo: synchronous byte FIFO, head visible on dout.
// Push when full and pop when empty are ignored.
module io_uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/io_uart_port.sv
// io_uart_port: I/O-port mapped 8N1 UART with TX/RX FIFOs.
// Receiver is built only when IO_UART_RX_EN is defined.
module io_uart_port
  import io_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int TX_DEPTH     = 8,
  parameter int RX_DEPTH     = 8
) (
  input  logic       clk100,
  input  logic       reset,
  input  logic [7:0] IO_port_ID,
  input  logic [7:0] IO_write_data,
  input  logic       IO_write_strobe,
  input  logic       IO_read_strobe,
  output logic [7:0] IO_read_data,
  output logic       uart_tx,
  input  logic       uart_rx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_dout;
  logic       rx_empty;
  logic [7:0] rx_dout;

  tx_state_t     tx_state, tx_next;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_sh, tx_sh_n;
  logic          tx_line_n;

  assign tx_push = IO_write_strobe && (IO_port_ID == PORT_DATA);

  io_uart_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk100), .rst(reset),
    .push(tx_push), .pop(tx_pop),
    .din(IO_write_data), .dout(tx_dout),
    .full(tx_full), .empty(tx_empty)
  );

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_next;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      uart_tx  <= tx_line_n;
    end
  end

  // Line is registered; tx_line_n is the level for the coming cycle.
  always_comb begin
    tx_next   = tx_state;
    tx_cnt_n  = tx_cnt;
    tx_bit_n  = tx_bit;
    tx_sh_n   = tx_sh;
    tx_line_n = uart_tx;
    tx_pop    = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        tx_line_n = 1'b1;
        if (!tx_empty) begin
          tx_pop    = 1'b1;
          tx_sh_n   = tx_dout;
          tx_cnt_n  = '0;
          tx_line_n = 1'b0;
          tx_next   = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n  = '0;
          tx_bit_n  = '0;
          tx_line_n = tx_sh[0];
          tx_next   = TX_DATA;
        end else tx_cnt_n = tx_cnt + CW'(1);
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) begin
            tx_line_n = 1'b1;
            tx_next   = TX_STOP;
          end else begin
            tx_bit_n  = tx_bit + 3'd1;
            tx_sh_n   = {1'b0, tx_sh[7:1]};
            tx_line_n = tx_sh[1];
          end
        end else tx_cnt_n = tx_cnt + CW'(1);
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          if (!tx_empty) begin
            tx_pop    = 1'b1;
            tx_sh_n   = tx_dout;
            tx_line_n = 1'b0;
            tx_next   = TX_START;
          end else begin
            tx_line_n = 1'b1;
            tx_next   = TX_IDLE;
          end
        end else tx_cnt_n = tx_cnt + CW'(1);
      end
      default: tx_next = TX_IDLE;
    endcase
  end

`ifdef IO_UART_RX_EN
  rx_state_t     rx_state, rx_next;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_sh, rx_sh_n;
  logic          rx_s1, rx_s2;
  logic          rx_push, rx_pop, rx_full;

  assign rx_pop = IO_read_strobe && (IO_port_ID == PORT_DATA);

  io_uart_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk100), .rst(reset),
    .push(rx_push), .pop(rx_pop),
    .din(rx_sh_n), .dout(rx_dout),
    .full(rx_full), .empty(rx_empty)
  );

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_s1    <= uart_rx;
      rx_s2    <= rx_s1;
      rx_state <= rx_next;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
    end
  end

  always_comb begin
    rx_next  = rx_state;
    rx_cnt_n = rx_cnt;
    rx_bit_n = rx_bit;
    rx_sh_n  = rx_sh;
    rx_push  = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (!rx_s2) begin
          rx_cnt_n = '0;
          rx_next  = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n = '0;
          rx_bit_n = '0;
          rx_next  = rx_s2 ? RX_IDLE : RX_DATA;
        end else rx_cnt_n = rx_cnt + CW'(1);
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n = '0;
          rx_sh_n  = {rx_s2, rx_sh[7:1]};
          rx_bit_n = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_next = RX_STOP;
        end else rx_cnt_n = rx_cnt + CW'(1);
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n = '0;
          rx_push  = rx_s2;
          rx_next  = RX_IDLE;
        end else rx_cnt_n = rx_cnt + CW'(1);
      end
      default: rx_next = RX_IDLE;
    endcase
  end
`else
  logic unused_rx;
  assign unused_rx = uart_rx ^ IO_read_strobe;
  assign rx_empty  = 1'b1;
  assign rx_dout   = STAT_CLR;
`endif

  always_comb begin
    IO_read_data = READ_DEFAULT;
    unique case (IO_port_ID)
      PORT_DATA:     IO_read_data = rx_empty ? STAT_CLR : rx_dout;
      PORT_RX_AVAIL: IO_read_data = rx_empty ? STAT_CLR : STAT_SET;
      PORT_TX_FULL:  IO_read_data = tx_full ? STAT_SET : STAT_CLR;
      default:       IO_read_data = READ_DEFAULT;
    endcase
  end

endmodule

// File: tb/tb_io_uart_port.sv
// tb_io_uart_port: directed + random checks of io_uart_port
// against a frame-level line monitor and queue models.
module tb_io_uart_port;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;

  typedef struct {
    logic [7:0]  b;
    bit          ok;
    int unsigned t;
  } frm_t;

  logic       clk100 = 1'b0;
  logic       reset;
  logic [7:0] IO_port_ID;
  logic [7:0] IO_write_data;
  logic       IO_write_strobe;
  logic       IO_read_strobe;
  logic       uart_rx;
  logic [7:0] IO_read_data;
  logic       uart_tx;

  int unsigned cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  frm_t mon_q[$];

  io_uart_port #(.CLKS_PER_BIT(CPB), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)) dut (
    .clk100(clk100), .reset(reset),
    .IO_port_ID(IO_port_ID), .IO_write_data(IO_write_data),
    .IO_write_strobe(IO_write_strobe), .IO_read_strobe(IO_read_strobe),
    .IO_read_data(IO_read_data), .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  always #5 clk100 = ~clk100;
  always @(posedge clk100) cyc <= cyc + 1;

  // Line monitor: decodes 8N1 frames, demanding each bit be flat for CPB cycles.
  logic [9:0]  m_fr;
  bit          m_ok;
  bit          m_ab;
  int unsigned m_st;
  always begin
    @(posedge clk100); #1;
    if (!reset && uart_tx === 1'b0) begin
      m_st = cyc; m_ok = 1'b1; m_ab = 1'b0; m_fr = '0;
      for (int k = 0; k < FRAME; k++) begin
        if (k > 0) begin @(posedge clk100); #1; end
        if (reset) begin m_ab = 1'b1; break; end
        if (k % CPB == 0) m_fr[k / CPB] = uart_tx;
        else if (uart_tx !== m_fr[k / CPB]) m_ok = 1'b0;
      end
      if (!m_ab)
        mon_q.push_back('{b: m_fr[8:1], ok: m_ok && !m_fr[0] && m_fr[9], t: m_st});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk100); #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    IO_port_ID = 8'h01; IO_write_data = b; IO_write_strobe = 1'b1;
    tick();
    IO_write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] p, output logic [7:0] v);
    IO_port_ID = p; #1; v = IO_read_data;
  endtask

  task automatic pop_rx(output logic [7:0] v);
    IO_port_ID = 8'h01; #1; v = IO_read_data;
    IO_read_strobe = 1'b1;
    tick();
    IO_read_strobe = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int limit);
    int w = 0;
    while (mon_q.size() < n && w < limit) begin tick(); w++; end
    check("frame_timeout", 32'(mon_q.size() >= n), 1);
  endtask

  task automatic send_tx_single(input logic [7:0] b);
    int unsigned w;
    frm_t f;
    write_byte(b);
    w = cyc;
    check("tx_idle_at_push", uart_tx, 1);
    wait_frames(1, FRAME + 40);
    if (mon_q.size() > 0) begin
      f = mon_q.pop_front();
      check("tx_byte", f.b, b);
      check("tx_frame_ok", f.ok, 1);
      check("tx_start_latency", f.t, w + 1);
    end
  endtask

  // Drives one frame on uart_rx while watching port 0x02; returns the
  // edge count (from the falling edge) at which it first reads 0xFF.
  task automatic send_rx(input logic [7:0] b, input bit good, output int first);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    IO_port_ID = 8'h02;
    first = -1;
    for (int i = 0; i < FRAME + 20; i++) begin
      if (i >= FRAME) uart_rx = 1'b1;
      else if (i / CPB == 9 && !good) uart_rx = (i % CPB) >= 12;
      else uart_rx = fr[i / CPB];
      tick();
      if (first < 0 && IO_read_data == 8'hFF) first = i + 1;
    end
  endtask

  logic [7:0] v;
  logic [7:0] lead;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] rb;
  int first;
  int occ;
  int unsigned prev_t;
  frm_t f;

  initial begin
    reset = 1'b1; IO_port_ID = 8'h00; IO_write_data = 8'h00;
    IO_write_strobe = 1'b0; IO_read_strobe = 1'b0; uart_rx = 1'b1;
    repeat (3) tick();
    check("tx_in_reset", uart_tx, 1);
    reset = 1'b0;
    tick();
    check("tx_idle_after_reset", uart_tx, 1);
    rd(8'h02, v); check("rst_port02", v, 8'h00);
    rd(8'h03, v); check("rst_port03", v, 8'h00);
    rd(8'h07, v); check("rst_port07", v, 8'hFF);
    rd(8'h01, v); check("rst_port01", v, 8'h00);

    send_tx_single(8'hA5);
    repeat (3) send_tx_single(8'($urandom));

    // Burst while a frame is in flight: FIFO fills, ninth byte dropped.
    lead = 8'($urandom);
    write_byte(lead);
    tick();
    exp_q.delete();
    exp_q.push_back(lead);
    occ = 0;
    for (int i = 0; i < 9; i++) begin
      if (i >= 7) begin
        rd(8'h03, v);
        check("tx_full_flag", v, (occ == DEPTH) ? 8'hFF : 8'h00);
      end
      write_byte(8'(i));
      if (occ < DEPTH) begin exp_q.push_back(8'(i)); occ++; end
    end
    rd(8'h03, v); check("tx_full_after_drop", v, 8'hFF);
    wait_frames(exp_q.size(), exp_q.size() * FRAME + 200);
    prev_t = 0;
    for (int i = 0; i < 9 && mon_q.size() > 0; i++) begin
      f = mon_q.pop_front();
      check("burst_byte", f.b, exp_q[i]);
      check("burst_frame_ok", f.ok, 1);
      if (i > 0) check("burst_contiguous", f.t, prev_t + FRAME);
      prev_t = f.t;
    end
    repeat (FRAME + 40) tick();
    check("burst_no_extra_frame", mon_q.size(), 0);

    // Reset in the middle of a start bit with bytes still queued.
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    repeat (4) tick();
    check("tx_low_before_reset", uart_tx, 0);
    reset = 1'b1;
    #1;
    check("tx_async_reset", uart_tx, 1);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    rd(8'h03, v); check("reset_tx_fifo_empty", v, 8'h00);
    rd(8'h02, v); check("reset_rx_fifo_empty", v, 8'h00);
    repeat (3 * FRAME) tick();
    check("reset_flushed_tx", mon_q.size(), 0);
    send_tx_single(8'h5A);

`ifdef IO_UART_RX_EN
    send_rx(8'h3C, 1'b1, first);
    check("rx_push_timing", 32'(first >= 153 && first <= 157), 1);
    pop_rx(v); check("rx_data_3c", v, 8'h3C);
    rd(8'h02, v); check("rx_empty_after_pop", v, 8'h00);

    rx_q.delete();
    for (int i = 0; i < 2; i++) begin
      rb = 8'($urandom);
      send_rx(rb, 1'b1, first);
      rx_q.push_back(rb);
    end
    rd(8'h02, v); check("rx_avail_two", v, 8'hFF);
    for (int i = 0; i < 2; i++) begin
      pop_rx(v); check("rx_rand_byte", v, rx_q[i]);
    end
    pop_rx(v); check("rx_pop_empty", v, 8'h00);
    rd(8'h02, v); check("rx_avail_cleared", v, 8'h00);

    IO_port_ID = 8'h02;
    first = -1;
    for (int i = 0; i < 4 * CPB; i++) begin
      uart_rx = (i >= 4);
      tick();
      if (IO_read_data == 8'hFF) first = i;
    end
    check("rx_glitch_no_push", first, -1);

    send_rx(8'h96, 1'b0, first);
    check("rx_framing_no_push", first, -1);
    rd(8'h02, v); check("rx_framing_port02", v, 8'h00);
`else
    send_rx(8'h3C, 1'b1, first);
    check("norx_no_push", first, -1);
    pop_rx(v); check("norx_port01", v, 8'h00);
    rd(8'h02, v); check("norx_port02", v, 8'h00);
    pop_rx(v); check("norx_port01_again", v, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
